ifu_prefetch: RTL

Parametrised instruction-fetch unit for the npc core. It replaces the single-cycle PC-register-plus-combinational-memory fetch path with a decoupled front end. It owns the fetch PC and issues in-order requests over a valid/ready memory port. Returned instructions and their PCs are buffered in a DEPTH-entry reservation queue, and control-flow redirects flush wrong-path work, including responses still in flight.

---
 rtl/ifu_prefetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: decoupled instruction-fetch front end for the npc core.
//
// The unit owns the fetch PC and issues in-order requests over a
// valid/ready memory port. Each accepted request reserves a queue slot
// tagged with its PC. Responses fill slots in order, and the decoder pops
// from the head. A redirect flushes the queue. Responses still owed for
// requests issued before the redirect are counted in drop_cnt and
// discarded when they arrive.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/ready  fetch request handshake, req_addr = fetch PC
//   resp_valid/inst  in-order memory response, one per accepted request
//   inst_valid/ready queue head handshake to the decoder
//   inst_out/inst_pc head instruction and its PC
//   redirect_valid   redirect request (highest priority), new PC in redirect_pc
//   misaligned       sticky: fetch halted on a redirect to a non-word-aligned PC
module ifu_prefetch #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [XLEN-1:0]   req_addr,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = $clog2(DEPTH + 1);
  // One bit wider than the pointers so budget and drop sums cannot overflow.
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [PW-1:0]     alloc_ptr;
  logic [PW-1:0]     fill_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DW-1:0]     drop_cnt;
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PW-1:0] reserved;
  logic [PW-1:0] in_flight;
  logic [CW-1:0] budget;
  logic [CW-1:0] redirect_drops;
  logic          req_fire;
  logic          pop;
  logic          resp_drop;
  logic          resp_fill;

  always_comb begin
    reserved  = alloc_ptr - rd_ptr;
    in_flight = alloc_ptr - fill_ptr;
    budget    = CW'(reserved) + CW'(drop_cnt);

    // The rst term holds the request low while reset is asserted, even
    // though the registers already show an idle, aligned state.
    req_valid = !rst && !misaligned && !redirect_valid && (budget < CW'(DEPTH));
    req_addr  = fetch_pc;
    req_fire  = req_valid && req_ready;

    inst_valid = (fill_ptr != rd_ptr) && !redirect_valid;
    inst_out   = inst_mem[rd_ptr[AW-1:0]];
    inst_pc    = pc_mem[rd_ptr[AW-1:0]];
    pop        = inst_valid && inst_ready;

    resp_drop = resp_valid && (drop_cnt != '0);
    resp_fill = resp_valid && (drop_cnt == '0);

    // A response in the redirect cycle retires one outstanding request,
    // whether it was live or already marked for dropping. Every other
    // live request in flight becomes a drop.
    redirect_drops = CW'(drop_cnt) + CW'(in_flight) - CW'(resp_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= '0;
      misaligned <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[AW'(i)]   <= '0;
        inst_mem[AW'(i)] <= '0;
      end
    end else if (redirect_valid) begin
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= DW'(redirect_drops);
      fetch_pc   <= redirect_pc;
      misaligned <= |redirect_pc[1:0];
    end else begin
      if (req_fire) begin
        pc_mem[alloc_ptr[AW-1:0]] <= fetch_pc;
        alloc_ptr                 <= alloc_ptr + PW'(1);
        fetch_pc                  <= fetch_pc + XLEN'(4);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
      if (resp_fill) begin
        inst_mem[fill_ptr[AW-1:0]] <= resp_inst;
        fill_ptr                   <= fill_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  logic [CW-1:0] outstanding;
  always_comb begin
    outstanding = CW'(in_flight) + CW'(drop_cnt);
  end

  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    resp_valid |-> (outstanding != '0));
  a_budget_cap: assert property (@(posedge clk) disable iff (rst)
    budget <= CW'(DEPTH));
  a_fill_behind_alloc: assert property (@(posedge clk) disable iff (rst)
    in_flight <= reserved);
`endif

endmodule
